// File: rtl/squarewave_generator_multi.sv
// squarewave_generator_multi: prescaled phase counter producing a PWM duty word.
// Define WAVEGEN_SHAPES_EN to build the sawtooth and triangle shapes selected by Mode.
module squarewave_generator_multi #(
  parameter int DUTY_W     = 7,
  parameter int PRESCALE_W = 6,
  parameter int SCALE_W    = 6,
  parameter int PHASE_W    = 6
) (
  input  logic                 sysclk,
  input  logic                 rst,
  input  logic                 Enable,
  input  logic                 Restart,
  input  logic [SCALE_W-1:0]   Scale,
  input  logic [PHASE_W-1:0]   Threshold,
  input  logic [1:0]           Mode,
  output logic [DUTY_W-1:0]    Duty_Output,
  output logic                 Period_Tick
);

  localparam logic [DUTY_W-1:0]     FULL_D    = {1'b1, {(DUTY_W-1){1'b0}}};
  localparam logic [DUTY_W-1:0]     DUTY_ZERO = {DUTY_W{1'b0}};
  localparam logic [SCALE_W-1:0]    SCALE_ONE = {{(SCALE_W-1){1'b0}}, 1'b1};
  localparam logic [PHASE_W-1:0]    PHASE_ONE = {{(PHASE_W-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_W-1:0] PRE_ONE   = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0] prescale_r, prescale_nxt_s;
  logic [SCALE_W-1:0]    step_r, step_nxt_s;
  logic [PHASE_W-1:0]    phase_r, phase_nxt_s;
  logic [DUTY_W-1:0]     duty_r, duty_nxt_s, square_s, shape_s;
  logic                  period_tick_r, period_tick_nxt_s;
  logic                  tick_s;

  assign tick_s = &prescale_r;

  // Counter next-state: Restart beats the tick; Scale==0 freezes step and phase.
  always_comb begin
    prescale_nxt_s    = prescale_r + PRE_ONE;
    step_nxt_s        = step_r;
    phase_nxt_s       = phase_r;
    period_tick_nxt_s = 1'b0;
    if (Restart) begin
      prescale_nxt_s = {PRESCALE_W{1'b0}};
      step_nxt_s     = {SCALE_W{1'b0}};
      phase_nxt_s    = {PHASE_W{1'b0}};
    end else if (tick_s && (Scale != {SCALE_W{1'b0}})) begin
      // >= lets a lowered Scale wrap on the next tick instead of running to 2^SCALE_W.
      if (step_r >= (Scale - SCALE_ONE)) begin
        step_nxt_s        = {SCALE_W{1'b0}};
        phase_nxt_s       = phase_r + PHASE_ONE;
        period_tick_nxt_s = &phase_r;
      end else begin
        step_nxt_s = step_r + SCALE_ONE;
      end
    end else begin
      step_nxt_s = step_r;
    end
  end

  assign square_s = (phase_r < Threshold) ? FULL_D : DUTY_ZERO;

`ifdef WAVEGEN_SHAPES_EN
  localparam int PROD_W = PHASE_W + DUTY_W + 1;
  localparam logic [PROD_W-1:0] FULL_P = {{(PROD_W-DUTY_W){1'b0}}, FULL_D};

  logic [PROD_W-1:0]  saw_prod_s, tri_prod_s;
  logic [PHASE_W-1:0] tri_idx_s;

  // Shape datapaths, full-width products before the phase-width shift.
  always_comb begin
    saw_prod_s = {{(PROD_W-PHASE_W){1'b0}}, phase_r} * FULL_P;
    tri_idx_s  = phase_r[PHASE_W-1] ? ~phase_r : phase_r;
    tri_prod_s = ({{(PROD_W-PHASE_W){1'b0}}, tri_idx_s} * FULL_P) << 1'b1;
    case (Mode)
      2'd1:    shape_s = DUTY_W'(saw_prod_s >> PHASE_W);
      2'd2:    shape_s = DUTY_W'(tri_prod_s >> PHASE_W);
      default: shape_s = square_s;
    endcase
  end
`else
  logic mode_unused_s;
  assign mode_unused_s = ^Mode;
  assign shape_s       = square_s;
`endif

  // Output gating: counters keep running while the output is disabled.
  always_comb begin
    if (Enable) begin
      duty_nxt_s = shape_s;
    end else begin
      duty_nxt_s = DUTY_ZERO;
    end
  end

  // State and output registers; rst clears everything.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      prescale_r    <= {PRESCALE_W{1'b0}};
      step_r        <= {SCALE_W{1'b0}};
      phase_r       <= {PHASE_W{1'b0}};
      duty_r        <= DUTY_ZERO;
      period_tick_r <= 1'b0;
    end else begin
      prescale_r    <= prescale_nxt_s;
      step_r        <= step_nxt_s;
      phase_r       <= phase_nxt_s;
      duty_r        <= duty_nxt_s;
      period_tick_r <= period_tick_nxt_s;
    end
  end

  assign Duty_Output = duty_r;
  assign Period_Tick = period_tick_r;

endmodule

// File: doc/squarewave_generator_multi.md
# squarewave_generator_multi

Parametrised successor of the fixed square-wave duty source. Produces a duty-cycle word for the downstream pulse-determination (PWM) block from a prescaled phase counter with programmable period scale, programmable square-wave threshold, enable gating, synchronous restart and a period-boundary strobe. Optional sawtooth and triangle shapes can be compiled in.

## Interface
- DUTY_W, 7, Duty_Output width. Full scale FULL = 2^(DUTY_W-1) (64 by default), so the PWM stage can reach 100%.
- PRESCALE_W, 6, prescaler width. One tick every 2^PRESCALE_W clocks.
- SCALE_W, 6, width of Scale.
- PHASE_W, 6, phase width. One waveform period is 2^PHASE_W phase steps.

Ports:
- sysclk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- Enable  in  1  1 = output active; 0 = Duty_Output forced to 0 (counters keep running)
- Restart  in  1  one-clock pulse that zeroes prescaler, step counter and phase
- Scale  in  SCALE_W  ticks per phase step; 0 = phase frozen
- Threshold  in  PHASE_W  square wave is high while phase < Threshold
- Mode  in  2  0 square, 1 sawtooth, 2 triangle, 3 = square (only with WAVEGEN_SHAPES_EN)
- Duty_Output  out  DUTY_W  registered duty word, 0..FULL
- Period_Tick  out  1  one-clock pulse when phase wraps from 2^PHASE_W-1 to 0

## Operation
- Prescaler: free-running; tick = prescaler all-ones.
- Step counter: on tick, if Scale != 0 and step >= Scale-1, then step <= 0 and phase advances; otherwise step increments. Using >= means lowering Scale mid-count wraps on the next tick, with no 2^SCALE_W runaway.
- Scale == 0: step and phase hold their values; output continues from the frozen phase.
- Phase advances modulo 2^PHASE_W. Period_Tick asserts on the same edge that phase loads 0 from a wrap.
- Square: FULL if phase < Threshold, else 0. Threshold 0 = constant 0; Threshold 2^(PHASE_W-1) = 50%.
- Sawtooth: (phase * FULL) >> PHASE_W, computed at full width before the shift (default: equals phase, 0..63).
- Triangle: if phase < 2^(PHASE_W-1), then (2*phase*FULL) >> PHASE_W; otherwise (2*(2^PHASE_W-1-phase)*FULL) >> PHASE_W (default: 0..62..0).
- Enable = 0: Duty_Output <= 0. Phase continuity is kept, so re-enable resumes mid-period.
- Restart has priority over the tick in the same clock. Restart does not assert Period_Tick.
- rst has priority over Restart. After rst: prescaler = 0, step = 0, phase = 0, Duty_Output = 0, Period_Tick = 0.

## Timing
- Duty_Output is registered from the current phase, Mode, Threshold and Enable, so any input change is visible 1 clock later.
- A phase change is visible on Duty_Output 1 clock after the phase register updates.
- Period_Tick is aligned with the clock in which phase becomes 0. Duty_Output for phase 0 follows 1 clock later.
- Period in clocks = 2^PRESCALE_W * Scale * 2^PHASE_W (defaults: 4096 * Scale).
- First phase step after reset or Restart occurs at clock 2^PRESCALE_W * Scale.
- Reset mid-period: the next clock shows all-zero state. There is no partial-period strobe.

## Configuration
- WAVEGEN_SHAPES_EN defined: Mode is decoded and the sawtooth and triangle datapaths are built.
- WAVEGEN_SHAPES_EN undefined: Mode is ignored, the output is always square, and no multiplier or shape logic is synthesised. The port still exists.

## Test plan
- PRESCALE_W=2, Scale=1, Threshold=32, Mode=0, Enable=1 after rst: Duty_Output = 64 for 128 clocks, then 0 for 128 clocks. Period_Tick pulses every 256 clocks.
- Same setup, Threshold=0: Duty_Output stays 0. Threshold=63: Duty_Output = 0 only while phase = 63 (4 clocks per period).
- Enable toggled 1 -> 0 -> 1 mid-high-phase: Duty_Output = 0 one clock after Enable falls, and returns to 64 one clock after Enable rises. Period_Tick spacing is unchanged.
- Scale=5, then switch to Scale=2 when step = 4: the phase advances on the next tick, then every 2 ticks. Scale=0: phase holds and Period_Tick stops.
- With WAVEGEN_SHAPES_EN, Mode=1, PRESCALE_W=2, Scale=1: Duty_Output ramps 0..63 in steps of 1 every 4 clocks. Mode=2 gives 0, 2, ..., 62, 62, ..., 0.
- Restart and rst asserted mid-period, including in the same clock as a phase wrap: all counters are 0 the next clock, Duty_Output = 0 after rst, and Period_Tick is not asserted.
